debug_unit: RTL and testbench

- Control and observation front-end for the MIPS pipeline top.
- Takes command bytes from a UART receiver and drives the pipeline's valid and reset inputs, allowing free-run, single-step, stop and reset.
- Serialises a state snapshot back through a UART transmitter: cycle counter, PC, then register-file and data-memory words read through a dump port.
- Sits directly upstream of the pipeline top and consumes the observation data it exports.

---
 rtl/debug_unit.sv | 141 ++++++++++++++
 tb/tb_debug_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// debug_unit: UART command front-end that runs, steps, stops and resets the MIPS pipeline
// and streams a counter/PC/register/memory snapshot back out byte by byte.
module debug_unit #(
    parameter int NB_REG       = 32,
    parameter int NB_BYTE      = 8,
    parameter int N_DUMP_WORDS = 64,
    parameter int NB_DUMP_ADDR = $clog2(N_DUMP_WORDS)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [NB_BYTE-1:0]      i_rx_data,
    input  logic                    i_rx_valid,
    output logic [NB_BYTE-1:0]      o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic                    o_pipe_valid,
    output logic                    o_pipe_reset,
    input  logic                    i_halt,
    input  logic [NB_REG-1:0]       i_pc,
    output logic [NB_DUMP_ADDR-1:0] o_dump_addr,
    input  logic [NB_REG-1:0]       i_dump_data,
    output logic                    o_busy
);
    localparam int N_BYTES = NB_REG / NB_BYTE;
    localparam int NB_BI   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_BI-1:0]        LAST_BYTE = NB_BI'(N_BYTES - 1);
    localparam logic [NB_DUMP_ADDR-1:0] LAST_ADDR = NB_DUMP_ADDR'(N_DUMP_WORDS - 1);
    localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(1);
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(2);
    localparam logic [NB_BYTE-1:0] CMD_DUMP = NB_BYTE'(3);
    localparam logic [NB_BYTE-1:0] CMD_STOP = NB_BYTE'(4);
    localparam logic [NB_BYTE-1:0] CMD_RST  = NB_BYTE'(5);

    typedef enum logic [2:0] {IDLE, RUN, STEP, RST, DUMP_LOAD, DUMP_WAIT, DUMP_SEND} state_t;
    typedef enum logic [1:0] {W_CNT, W_PC, W_MEM} word_t;

    state_t                  state_q;
    word_t                   word_q;
    logic                    pipe_valid_q, pipe_reset_q, halted_q, tx_valid_q;
    logic [NB_REG-1:0]       cnt_q, cnt_d, pc_q, sh_q;
    logic [NB_DUMP_ADDR-1:0] addr_q;
    logic [NB_BI-1:0]        bidx_q;
    logic                    cmd_run, cmd_step, cmd_dump, cmd_stop, cmd_rst, tx_accept;

    assign cmd_run   = i_rx_valid && i_rx_data == CMD_RUN;
    assign cmd_step  = i_rx_valid && i_rx_data == CMD_STEP;
    assign cmd_dump  = i_rx_valid && i_rx_data == CMD_DUMP;
    assign cmd_stop  = i_rx_valid && i_rx_data == CMD_STOP;
    assign cmd_rst   = i_rx_valid && i_rx_data == CMD_RST;
    assign tx_accept = tx_valid_q && i_tx_ready;
    assign cnt_d     = cnt_q + NB_REG'(pipe_valid_q);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            word_q       <= W_CNT;
            pipe_valid_q <= 1'b0;
            pipe_reset_q <= 1'b1;
            halted_q     <= 1'b0;
            tx_valid_q   <= 1'b0;
            cnt_q        <= '0;
            pc_q         <= '0;
            sh_q         <= '0;
            addr_q       <= '0;
            bidx_q       <= '0;
        end else begin
            cnt_q        <= cnt_d;
            pipe_reset_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((cmd_run || cmd_step) && !halted_q) begin
                        state_q      <= cmd_run ? RUN : STEP;
                        pipe_valid_q <= 1'b1;
                    end else if (cmd_rst) begin
                        state_q      <= RST;
                        pipe_reset_q <= 1'b1;
                        cnt_q        <= '0;
                        halted_q     <= 1'b0;
                    end else if (cmd_dump) begin
                        // counter and PC are frozen here so the snapshot is coherent
                        state_q    <= DUMP_SEND;
                        word_q     <= W_CNT;
                        pc_q       <= i_pc;
                        sh_q       <= cnt_q;
                        tx_valid_q <= 1'b1;
                        bidx_q     <= '0;
                    end
                end
                RUN: begin
                    if (i_halt || cmd_stop) begin
                        state_q      <= IDLE;
                        pipe_valid_q <= 1'b0;
                        halted_q     <= i_halt;
                    end
                end
                STEP: begin
                    state_q      <= IDLE;
                    pipe_valid_q <= 1'b0;
                end
                RST:       state_q <= IDLE;
                DUMP_LOAD: state_q <= DUMP_WAIT;
                DUMP_WAIT: begin
                    state_q    <= DUMP_SEND;
                    word_q     <= W_MEM;
                    sh_q       <= i_dump_data;
                    tx_valid_q <= 1'b1;
                end
                DUMP_SEND: begin
                    if (tx_accept) begin
                        sh_q   <= sh_q << NB_BYTE;
                        bidx_q <= bidx_q + NB_BI'(1);
                        if (bidx_q == LAST_BYTE) begin
                            bidx_q <= '0;
                            if (word_q == W_CNT) begin
                                sh_q   <= pc_q;
                                word_q <= W_PC;
                            end else begin
                                tx_valid_q <= 1'b0;
                                if (word_q == W_MEM && addr_q == LAST_ADDR) begin
                                    state_q <= IDLE;
                                    addr_q  <= '0;
                                end else begin
                                    state_q <= DUMP_LOAD;
                                    addr_q  <= (word_q == W_MEM) ? addr_q + NB_DUMP_ADDR'(1) : addr_q;
                                end
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_tx_data    = sh_q[NB_REG-1 -: NB_BYTE];
    assign o_tx_valid   = tx_valid_q;
    assign o_pipe_valid = pipe_valid_q;
    assign o_pipe_reset = pipe_reset_q;
    assign o_dump_addr  = addr_q;
    assign o_busy       = state_q != IDLE;
endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit: directed stimulus with a rule-level reference model checked every cycle,
// plus literal expectations on dumped snapshot words.
module tb_debug_unit;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_RST = 3, M_DUMP = 4;

    logic        clk = 1'b0;
    logic        i_reset, i_rx_valid, i_tx_ready, i_halt;
    logic [7:0]  i_rx_data;
    logic [31:0] i_pc, i_dump_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid, o_pipe_valid, o_pipe_reset, o_busy;
    logic [5:0]  o_dump_addr;

    int          n_chk = 0, n_fail = 0;
    int          mode;
    logic [31:0] cnt;
    bit          halted, e_valid, e_preset, first, stalled;
    logic [7:0]  held;
    logic [7:0]  exp_q[$], got_q[$];

    debug_unit dut (
        .i_clock(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_pipe_valid(o_pipe_valid), .o_pipe_reset(o_pipe_reset), .i_halt(i_halt),
        .i_pc(i_pc), .o_dump_addr(o_dump_addr), .i_dump_data(i_dump_data), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // synchronous-read snapshot memory: word a holds a*4
    always @(posedge clk) i_dump_data <= 32'(o_dump_addr) << 2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input int idx);
        return {got_q[idx], got_q[idx+1], got_q[idx+2], got_q[idx+3]};
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!i_reset) begin
                chk("rst_pipe_valid", o_pipe_valid, 0);
                chk("rst_pipe_reset", o_pipe_reset, 1);
                chk("rst_tx_valid", o_tx_valid, 0);
                chk("rst_busy", o_busy, 0);
                chk("rst_dump_addr", o_dump_addr, 0);
                mode = M_IDLE; cnt = 0; halted = 0; e_valid = 0; e_preset = 1; stalled = 0; first = 0;
                exp_q.delete();
            end else begin
                chk("pipe_valid", o_pipe_valid, e_valid);
                chk("pipe_reset", o_pipe_reset, e_preset);
                chk("busy", o_busy, mode != M_IDLE);
                if (mode != M_DUMP) begin
                    chk("tx_valid_quiet", o_tx_valid, 0);
                    chk("dump_addr_quiet", o_dump_addr, 0);
                end else begin
                    if (first) chk("tx_first_valid", o_tx_valid, 1);
                    if (stalled) begin
                        chk("tx_hold_valid", o_tx_valid, 1);
                        chk("tx_hold_data", o_tx_data, held);
                    end
                    first = 0;
                    stalled = o_tx_valid && !i_tx_ready;
                    held = o_tx_data;
                    if (o_tx_valid && i_tx_ready) begin
                        got_q.push_back(o_tx_data);
                        if (exp_q.size() == 0) begin
                            n_chk++; n_fail++;
                            $display("FAIL tx_extra_byte: got 0x%0h, expected no byte at %0t", o_tx_data, $time);
                        end else chk("tx_byte", o_tx_data, exp_q.pop_front());
                    end
                end
                cnt += 32'(e_valid);
                e_preset = 0;
                case (mode)
                    M_IDLE: if (i_rx_valid) begin
                        if ((i_rx_data == 8'h01 || i_rx_data == 8'h02) && !halted) begin
                            mode = (i_rx_data == 8'h01) ? M_RUN : M_STEP;
                            e_valid = 1;
                        end else if (i_rx_data == 8'h05) begin
                            mode = M_RST; e_preset = 1; cnt = 0; halted = 0;
                        end else if (i_rx_data == 8'h03) begin
                            exp_q.delete(); got_q.delete();
                            push_word(cnt);
                            push_word(i_pc);
                            for (int a = 0; a < 64; a++) push_word(32'(a * 4));
                            mode = M_DUMP; first = 1; stalled = 0;
                        end
                    end
                    M_RUN: if (i_halt || (i_rx_valid && i_rx_data == 8'h04)) begin
                        mode = M_IDLE; e_valid = 0;
                        if (i_halt) halted = 1;
                    end
                    M_STEP: begin mode = M_IDLE; e_valid = 0; end
                    M_RST:  mode = M_IDLE;
                    M_DUMP: if (exp_q.size() == 0) mode = M_IDLE;
                    default: mode = M_IDLE;
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_data = b;
        i_rx_valid = 1;
        tick();
        i_rx_valid = 0;
    endtask

    task automatic wait_idle(input int limit, input bit tog);
        int i = 0;
        while (mode != M_IDLE && i < limit) begin
            if (tog) i_tx_ready = ~i_tx_ready;
            tick();
            i++;
        end
        i_tx_ready = 1;
        if (mode != M_IDLE) begin
            n_chk++; n_fail++;
            $display("FAIL dump_timeout: still busy after %0d cycles, expected idle", limit);
        end
    endtask

    initial begin
        i_reset = 0; i_rx_valid = 0; i_rx_data = 0; i_tx_ready = 1; i_halt = 0; i_pc = 0;
        fork monitor(); join_none
        repeat (3) tick();
        i_reset = 1;
        tick();
        chk("release_pipe_reset", o_pipe_reset, 0);
        send(8'h7F);
        send(8'h04);
        tick();
        // three single steps, then dump the counter
        repeat (3) begin
            send(8'h02);
            chk("step_pulse", o_pipe_valid, 1);
            tick();
        end
        send(8'h03);
        chk("dump_first_valid", o_tx_valid, 1);
        chk("dump_first_byte", o_tx_data, 8'h00);
        wait_idle(2000, 0);
        chk("t1_len", got_q.size(), 264);
        chk("t1_counter", word_at(0), 32'h3);
        chk("t1_last_word", word_at(260), 32'hFC);
        send(8'h05);
        tick();
        // run until halt raised on the 11th valid cycle
        i_pc = 32'h40;
        send(8'h01);
        repeat (10) tick();
        i_halt = 1;
        tick();
        i_halt = 0;
        chk("halt_valid_drop", o_pipe_valid, 0);
        send(8'h02);
        chk("step_while_halted", o_pipe_valid, 0);
        send(8'h03);
        wait_idle(2000, 1);
        chk("t2_len", got_q.size(), 264);
        chk("t2_counter", word_at(0), 32'hB);
        chk("t2_pc", word_at(4), 32'h40);
        chk("t2_mem0", word_at(8), 32'h0);
        chk("t2_mem1", word_at(12), 32'h4);
        chk("t2_mem63", word_at(260), 32'hFC);
        // reset command clears counter and halted flag
        send(8'h05);
        chk("rstcmd_pulse", o_pipe_reset, 1);
        chk("rstcmd_no_valid", o_pipe_valid, 0);
        tick();
        chk("rstcmd_pulse_end", o_pipe_reset, 0);
        chk("rstcmd_idle", o_busy, 0);
        send(8'h03);
        wait_idle(2000, 0);
        chk("t5_counter", word_at(0), 32'h0);
        // run with a dropped STEP byte, then STOP
        send(8'h01);
        chk("run_after_reset", o_pipe_valid, 1);
        repeat (3) tick();
        send(8'h02);
        repeat (2) tick();
        send(8'h04);
        chk("stop_valid_low", o_pipe_valid, 0);
        chk("stop_not_busy", o_busy, 0);
        tick();
        // asynchronous reset in the middle of a dump
        send(8'h03);
        repeat (5) tick();
        chk("mid_dump_sending", o_tx_valid, 1);
        #2 i_reset = 0;
        #1;
        chk("async_tx_valid", o_tx_valid, 0);
        chk("async_pipe_reset", o_pipe_reset, 1);
        chk("async_busy", o_busy, 0);
        tick();
        i_reset = 1;
        tick();
        chk("post_reset_busy", o_busy, 0);
        chk("post_reset_pipe_reset", o_pipe_reset, 0);
        chk("post_reset_tx_valid", o_tx_valid, 0);
        send(8'h03);
        wait_idle(2000, 1);
        chk("t6_len", got_q.size(), 264);
        chk("t6_counter", word_at(0), 32'h0);
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
